// File: rtl/fp_to_tc.sv
// rtl/fp_to_tc.sv - sign/exponent/significand to 12-bit two's-complement decoder
//
// Decodes D = F * 2^E (negated when S=1) using a serial shifter, one
// transaction in flight at a time. Result latency is E+2 edges after the
// acceptance edge.
//
// Optional feature: define FP_TO_TC_CANON_CHECK_EN to flag non-canonical
// inputs (E!=0 with F[3]=0); such inputs yield D=0 and err=1. Without the
// macro err is tied low.
//
// Ports:
//   clk        sole clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   S/E/F valid this cycle
//   in_ready   registered, high only in IDLE once out of reset
//   S, E, F    sign, 3-bit exponent, 4-bit significand
//   out_valid  D/err hold a result
//   out_ready  consumer accepts the result
//   D          12-bit two's-complement result
//   err        non-canonical input flag

module fp_to_tc (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        S,
    input  logic [2:0]  E,
    input  logic [3:0]  F,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [11:0] D,
    output logic        err
);

    typedef enum logic [1:0] {IDLE, SHIFT, NEG, DONE} state_t;

    state_t      state;
    state_t      next_state;
    logic        sign;
    logic [2:0]  cnt;
    logic [11:0] mag;
    logic        accept;

    // in_ready is only ever set while in IDLE, so this is the handshake.
    assign accept = (state == IDLE) && in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept) next_state = SHIFT;
            SHIFT:   if (cnt == 3'd0) next_state = NEG;
            NEG:     next_state = DONE;
            DONE:    if (out_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

`ifdef FP_TO_TC_CANON_CHECK_EN
    logic bad;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bad <= 1'b0;
            err <= 1'b0;
        end else begin
            if (accept) begin
                bad <= (E != 3'd0) && !F[3];
            end
            if (state == NEG) begin
                err <= bad;
            end
        end
    end
`else
    assign err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            D         <= 12'h000;
            sign      <= 1'b0;
            cnt       <= 3'd0;
            mag       <= 12'h000;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        sign     <= S;
                        cnt      <= E;
                        mag      <= {8'b0, F};
                        in_ready <= 1'b0;
                    end else begin
                        // First edge after reset release raises in_ready.
                        in_ready <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (cnt != 3'd0) begin
                        mag <= mag << 1;
                        cnt <= cnt - 3'd1;
                    end
                end
                NEG: begin
`ifdef FP_TO_TC_CANON_CHECK_EN
                    if (bad) begin
                        D <= 12'h000;
                    end else begin
                        D <= sign ? (~mag + 12'd1) : mag;
                    end
`else
                    // ~0+1 wraps to 0, so F=0 never produces negative zero.
                    D <= sign ? (~mag + 12'd1) : mag;
`endif
                    out_valid <= 1'b1;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    in_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fp_to_tc.sv
// tb/tb_fp_to_tc.sv - self-checking bench for fp_to_tc
module tb_fp_to_tc;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        S = 1'b0;
    logic [2:0]  E = 3'd0;
    logic [3:0]  F = 4'd0;
    logic        out_ready = 1'b0;
    logic        in_ready;
    logic        out_valid;
    logic [11:0] D;
    logic        err;

    int checks = 0;
    int failures = 0;

`ifdef FP_TO_TC_CANON_CHECK_EN
    localparam bit CANON = 1'b1;
`else
    localparam bit CANON = 1'b0;
`endif

    typedef struct {
        bit       s;
        int       e;
        int       f;
        int       exp_d;
        int       exp_err;
        int       hold;
    } vec_t;

    vec_t vecs[8];

    always #5 clk = ~clk;

    fp_to_tc dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .S         (S),
        .E         (E),
        .F         (F),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .D         (D),
        .err       (err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Reference: plain arithmetic on the numeric value.
    function automatic void model(input bit s, input int e, input int f,
                                  output int d, output int er);
        int value;
        value = f * (2 ** e);
        if (CANON && e != 0 && f < 8) begin
            d  = 0;
            er = 1;
        end else begin
            d  = s ? ((4096 - value) % 4096) : value;
            er = 0;
        end
    endfunction

    task automatic run_txn(input string tag, input bit s, input int e, input int f,
                           input int exp_d, input int exp_err, input int hold);
        int n;
        int lat;
        bit busy_ok;
        bit hold_ok;
        logic [11:0] d_seen;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk($sformatf("%s ready_before", tag), in_ready, 1);
        S = s;
        E = e[2:0];
        F = f[3:0];
        in_valid = 1'b1;
        @(posedge clk); #1;
        lat = 0;
        busy_ok = 1'b1;
        // While busy: garbage inputs and stray out_ready must be ignored.
        while (!out_valid && lat < 20) begin
            if (in_ready) busy_ok = 1'b0;
            in_valid  = 1'($urandom_range(0, 1));
            S         = 1'($urandom);
            E         = 3'($urandom);
            F         = 4'($urandom);
            out_ready = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            lat++;
        end
        out_ready = 1'b0;
        in_valid  = 1'b0;
        chk($sformatf("%s latency", tag), lat, e + 2);
        chk($sformatf("%s busy_in_ready", tag), busy_ok, 1);
        chk($sformatf("%s D", tag), D, exp_d);
        chk($sformatf("%s err", tag), err, exp_err);
        d_seen = D;
        hold_ok = 1'b1;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            if (D !== d_seen || out_valid !== 1'b1 || in_ready !== 1'b0 || err !== 1'(exp_err))
                hold_ok = 1'b0;
        end
        if (hold > 0) chk($sformatf("%s hold_stable", tag), hold_ok, 1);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk($sformatf("%s release_valid", tag), out_valid, 0);
        chk($sformatf("%s release_ready", tag), in_ready, 1);
        chk($sformatf("%s D_retained", tag), D, exp_d);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int md;
        int me;
        bit rs;
        int re;
        int rf;

        vecs[0] = '{1'b0, 0, 5,  'h005, 0, 0};
        vecs[1] = '{1'b1, 7, 15, 'h880, 0, 0};
        vecs[2] = '{1'b0, 3, 11, 'h058, 0, 3};
        vecs[3] = '{1'b1, 5, 0,  'h000, CANON ? 1 : 0, 0};
        vecs[4] = '{1'b0, 4, 5,  CANON ? 'h000 : 'h050, CANON ? 1 : 0, 1};
        vecs[5] = '{1'b1, 0, 1,  'hFFF, 0, 2};
        vecs[6] = '{1'b1, 3, 8,  'hFC0, 0, 0};
        vecs[7] = '{1'b0, 7, 8,  'h400, 0, 1};

        // Reset state across clock edges.
        @(posedge clk); @(posedge clk); #1;
        chk("reset in_ready", in_ready, 0);
        chk("reset out_valid", out_valid, 0);
        chk("reset D", D, 0);
        chk("reset err", err, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("first_edge in_ready", in_ready, 1);

        foreach (vecs[i])
            run_txn($sformatf("vec%0d", i), vecs[i].s, vecs[i].e, vecs[i].f,
                    vecs[i].exp_d, vecs[i].exp_err, vecs[i].hold);

        // Reset during SHIFT abandons the transaction.
        S = 1'b1; E = 3'd6; F = 4'd9; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("midreset out_valid", out_valid, 0);
        chk("midreset D", D, 0);
        chk("midreset in_ready", in_ready, 0);
        @(posedge clk); #1;
        chk("midreset held in_ready", in_ready, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("postreset in_ready", in_ready, 1);
        chk("postreset out_valid", out_valid, 0);
        run_txn("after_reset", 1'b0, 1, 8, 'h010, 0, 0);

        // Randomised transactions against the arithmetic model.
        for (int k = 0; k < 40; k++) begin
            rs = 1'($urandom);
            re = $urandom_range(0, 7);
            rf = $urandom_range(0, 15);
            model(rs, re, rf, md, me);
            run_txn($sformatf("rand%0d", k), rs, re, rf, md, me, $urandom_range(0, 3));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
